// File: rtl/llc_snoop_responder_pkg.sv
// rtl/llc_snoop_responder_pkg.sv - shared types and geometry for the LLC snoop responder
// Contents: cache geometry constants, MESI/line state types, snoop op/result
// codes, L1 message codes and a line-alignment helper.
package llc_snoop_responder_pkg;

    localparam int ADDR_SIZE   = 32;
    localparam int N_WAY       = 16;
    localparam int INDEX_SIZE  = 14;
    localparam int OFFSET_SIZE = 6;
    localparam int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
    localparam int LINE_W      = 16;
    localparam int WAY_W       = 4;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef struct packed {
        mesi_e                 mesi;
        logic                  dirty;
        logic                  valid;
        logic [TAG_SIZE-1:0]   tag;
    } line_st;

    typedef enum logic [1:0] {
        SNP_READ       = 2'b00,
        SNP_WRITE      = 2'b01,
        SNP_INVALIDATE = 2'b10,
        SNP_RWIM       = 2'b11
    } snoop_op_e;

    typedef enum logic [1:0] {
        RSP_HIT   = 2'b00,
        RSP_HITM  = 2'b01,
        RSP_NOHIT = 2'b10
    } snoop_rsp_e;

    typedef enum logic [2:0] {
        L1_NONE           = 3'd0,
        L1_GETLINE        = 3'd1,
        L1_SENDLINE       = 3'd2,
        L1_INVALIDATELINE = 3'd3,
        L1_EVICTLINE      = 3'd4
    } l1_msg_e;

    function automatic logic [ADDR_SIZE-1:0] line_addr(input logic [ADDR_SIZE-1:0] a);
        return {a[ADDR_SIZE-1:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};
    endfunction

endpackage

// File: rtl/llc_snoop_responder_if.sv
// rtl/llc_snoop_responder_if.sv - bus bundle between snoop responder and its neighbours
// Groups: snoop request (snp_*), tag array read/write (ta_*), snoop result
// (rsp_*), modified-line write-back (wb_*), L1 message (l1_*) and err.
// slave = responder side, master = bus monitor / tag array / L1 side.
interface llc_snoop_responder_if;
    import llc_snoop_responder_pkg::*;

    logic                       snp_valid;
    logic                       snp_ready;
    logic [1:0]                 snp_op;
    logic [ADDR_SIZE-1:0]       snp_addr;

    logic                       ta_rd_en;
    logic [INDEX_SIZE-1:0]      ta_rd_index;
    logic [N_WAY*LINE_W-1:0]    ta_rd_data;
    logic                       ta_wr_en;
    logic [INDEX_SIZE-1:0]      ta_wr_index;
    logic [WAY_W-1:0]           ta_wr_way;
    logic [LINE_W-1:0]          ta_wr_line;

    logic                       rsp_valid;
    logic [1:0]                 rsp_result;

    logic                       wb_valid;
    logic                       wb_ready;
    logic [ADDR_SIZE-1:0]       wb_addr;

    logic                       l1_msg_valid;
    logic [2:0]                 l1_msg;
    logic [ADDR_SIZE-1:0]       l1_addr;

    logic                       err;

    modport slave (
        input  snp_valid, snp_op, snp_addr, ta_rd_data, wb_ready,
        output snp_ready, ta_rd_en, ta_rd_index, ta_wr_en, ta_wr_index, ta_wr_way,
               ta_wr_line, rsp_valid, rsp_result, wb_valid, wb_addr,
               l1_msg_valid, l1_msg, l1_addr, err
    );

    modport master (
        output snp_valid, snp_op, snp_addr, ta_rd_data, wb_ready,
        input  snp_ready, ta_rd_en, ta_rd_index, ta_wr_en, ta_wr_index, ta_wr_way,
               ta_wr_line, rsp_valid, rsp_result, wb_valid, wb_addr,
               l1_msg_valid, l1_msg, l1_addr, err
    );

endinterface

// File: rtl/llc_way_match.sv
// rtl/llc_way_match.sv - combinational tag match across all ways of one set
// Ports: set_i (all ways, way w at [w*LINE_W +: LINE_W]), tag_i;
//        hit_o, way_o (lowest matching way), line_o (its state), multi_hit_o.
module llc_way_match
    import llc_snoop_responder_pkg::*;
(
    input  logic [N_WAY*LINE_W-1:0] set_i,
    input  logic [TAG_SIZE-1:0]     tag_i,
    output logic                    hit_o,
    output logic [WAY_W-1:0]        way_o,
    output line_st                  line_o,
    output logic                    multi_hit_o
);

    line_st cand;

    // Scan from the top way down so the last match found is the lowest index;
    // any match after the first means more than one way holds the tag.
    always_comb begin
        hit_o       = 1'b0;
        way_o       = '0;
        line_o      = '0;
        multi_hit_o = 1'b0;
        cand        = '0;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            cand = set_i[w*LINE_W +: LINE_W];
            if (cand.valid && (cand.mesi != MESI_I) && (cand.tag == tag_i)) begin
                if (hit_o) begin
                    multi_hit_o = 1'b1;
                end
                hit_o  = 1'b1;
                way_o  = WAY_W'(w);
                line_o = cand;
            end
        end
    end

endmodule

// File: rtl/llc_snoop_responder.sv
// rtl/llc_snoop_responder.sv - LLC snoop responder: lookup, MESI update, write-back, L1 messages
// Ports: clk, rst_n (async, active-low), bus (llc_snoop_responder_if.slave).
module llc_snoop_responder
    import llc_snoop_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    llc_snoop_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_COMPARE,
        ST_WB,
        ST_INV
    } state_e;

    state_e               state_q;
    snoop_op_e            op_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic                 rd_en_q;
    logic                 wb_valid_q;
    logic                 inv_q;

    logic [TAG_SIZE-1:0]   tag_q;
    logic [INDEX_SIZE-1:0] index_q;
    assign tag_q   = addr_q[ADDR_SIZE-1 -: TAG_SIZE];
    assign index_q = addr_q[OFFSET_SIZE +: INDEX_SIZE];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    line_st           hit_line;
    logic             multi_hit;

    llc_way_match u_way_match (
        .set_i       (bus.ta_rd_data),
        .tag_i       (tag_q),
        .hit_o       (hit),
        .way_o       (hit_way),
        .line_o      (hit_line),
        .multi_hit_o (multi_hit)
    );

    // Decision for the COMPARE cycle. Set data arrives this cycle, so the
    // result is decoded combinationally and qualified by the state below.
    snoop_rsp_e rsp_d;
    logic       wr_d;
    line_st     wr_line_d;
    logic       msg_valid_d;
    l1_msg_e    msg_d;
    logic       err_d;
    logic       to_wb_d;

    always_comb begin
        rsp_d       = RSP_NOHIT;
        wr_d        = 1'b0;
        wr_line_d   = hit_line;
        msg_valid_d = 1'b0;
        msg_d       = L1_NONE;
        err_d       = multi_hit;
        to_wb_d     = 1'b0;
        if (hit) begin
            unique case (op_q)
                SNP_READ: begin
                    wr_d           = 1'b1;
                    wr_line_d.mesi = MESI_S;
                    if (hit_line.mesi == MESI_M) begin
                        rsp_d           = RSP_HITM;
                        wr_line_d.dirty = 1'b0;
                        msg_valid_d     = 1'b1;
                        msg_d           = L1_GETLINE;
                        to_wb_d         = 1'b1;
                    end else begin
                        rsp_d = RSP_HIT;
                    end
                end
                SNP_RWIM: begin
                    wr_d            = 1'b1;
                    wr_line_d.mesi  = MESI_I;
                    wr_line_d.valid = 1'b0;
                    msg_valid_d     = 1'b1;
                    if (hit_line.mesi == MESI_M) begin
                        rsp_d           = RSP_HITM;
                        wr_line_d.dirty = 1'b0;
                        msg_d           = L1_GETLINE;
                        to_wb_d         = 1'b1;
                    end else begin
                        rsp_d = RSP_HIT;
                        msg_d = L1_INVALIDATELINE;
                    end
                end
                SNP_INVALIDATE: begin
                    // Another cache cannot invalidate a line we own exclusively.
                    if (hit_line.mesi == MESI_S) begin
                        rsp_d           = RSP_HIT;
                        wr_d            = 1'b1;
                        wr_line_d.mesi  = MESI_I;
                        wr_line_d.valid = 1'b0;
                        msg_valid_d     = 1'b1;
                        msg_d           = L1_INVALIDATELINE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                SNP_WRITE: begin
                    if ((hit_line.mesi == MESI_M) || (hit_line.mesi == MESI_E)) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic in_cmp;
    logic wr_fire;
    assign in_cmp  = (state_q == ST_COMPARE);
    assign wr_fire = in_cmp && wr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= SNP_READ;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            inv_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.snp_valid) begin
                        op_q    <= snoop_op_e'(bus.snp_op);
                        addr_q  <= bus.snp_addr;
                        rd_en_q <= 1'b1;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    state_q <= ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (to_wb_d) begin
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_WB;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    if (bus.wb_ready) begin
                        wb_valid_q <= 1'b0;
                        if (op_q == SNP_RWIM) begin
                            inv_q   <= 1'b1;
                            state_q <= ST_INV;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_INV: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.snp_ready   = (state_q == ST_IDLE);
    assign bus.ta_rd_en    = rd_en_q;
    assign bus.ta_rd_index = index_q;

    assign bus.ta_wr_en    = wr_fire;
    assign bus.ta_wr_index = wr_fire ? index_q : '0;
    assign bus.ta_wr_way   = wr_fire ? hit_way : '0;
    assign bus.ta_wr_line  = wr_fire ? wr_line_d : '0;

    assign bus.rsp_valid   = in_cmp;
    assign bus.rsp_result  = in_cmp ? rsp_d : 2'b00;

    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_addr     = wb_valid_q ? line_addr(addr_q) : '0;

    // GETLINE can only come from COMPARE and INVALIDATELINE after a write-back
    // only from INV, so the two sources never collide.
    assign bus.l1_msg_valid = (in_cmp && msg_valid_d) || inv_q;
    assign bus.l1_msg       = inv_q ? L1_INVALIDATELINE :
                              ((in_cmp && msg_valid_d) ? msg_d : L1_NONE);
    assign bus.l1_addr      = bus.l1_msg_valid ? line_addr(addr_q) : '0;

    assign bus.err          = in_cmp && err_d;

endmodule

// File: tb/tb_llc_snoop_responder.sv
// tb/tb_llc_snoop_responder.sv - self-checking bench for llc_snoop_responder
module tb_llc_snoop_responder;
    import llc_snoop_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    llc_snoop_responder_if bus();

    llc_snoop_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tag array model: one-cycle read latency.
    logic [N_WAY*LINE_W-1:0] mem [int];
    logic [N_WAY*LINE_W-1:0] rd_data_q;
    always @(posedge clk) begin
        if (bus.ta_rd_en)
            rd_data_q <= mem.exists(int'(bus.ta_rd_index)) ? mem[int'(bus.ta_rd_index)] : '0;
    end
    assign bus.ta_rd_data = rd_data_q;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [3:0]  way;
        logic [15:0] line;
        logic        has2;
        logic [3:0]  way2;
        logic [15:0] line2;
        logic [1:0]  e_rsp;
        logic        e_wr;
        logic [15:0] e_line;
        logic        e_msgv;
        logic [2:0]  e_msg;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [1:0]  rsp;
        logic        wr;
        logic [3:0]  way;
        logic [15:0] line;
        logic [13:0] idx;
        logic        msgv;
        logic [2:0]  msg;
        logic [31:0] laddr;
        logic        err;
    } exp_t;

    exp_t expq[$];
    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] rsp, input logic wr, input logic [3:0] way,
                            input logic [15:0] line, input logic [31:0] addr, input logic msgv,
                            input logic [2:0] msg, input logic err);
        exp_t e;
        e.rsp = rsp; e.wr = wr; e.way = way; e.line = line; e.idx = addr[19:6];
        e.msgv = msgv; e.msg = msg; e.laddr = {addr[31:6], 6'b0}; e.err = err;
        expq.push_back(e);
    endtask

    // Scoreboard: pop one expectation per response strobe.
    always @(negedge clk) begin
        exp_t e;
        if (bus.ta_wr_en && !bus.rsp_valid) chk("wr_outside_compare", 32'd1, 32'd0);
        if (bus.rsp_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("rsp_result", 32'(bus.rsp_result), 32'(e.rsp));
                chk("err", 32'(bus.err), 32'(e.err));
                chk("ta_wr_en", 32'(bus.ta_wr_en), 32'(e.wr));
                if (e.wr) begin
                    chk("ta_wr_way", 32'(bus.ta_wr_way), 32'(e.way));
                    chk("ta_wr_line", 32'(bus.ta_wr_line), 32'(e.line));
                    chk("ta_wr_index", 32'(bus.ta_wr_index), 32'(e.idx));
                end
                chk("l1_msg_valid", 32'(bus.l1_msg_valid), 32'(e.msgv));
                if (e.msgv) begin
                    chk("l1_msg", 32'(bus.l1_msg), 32'(e.msg));
                    chk("l1_addr", bus.l1_addr, e.laddr);
                end
            end
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [3:0] way, input logic [15:0] line,
                           input logic has2, input logic [3:0] way2, input logic [15:0] line2);
        logic [N_WAY*LINE_W-1:0] s;
        s = '0;
        s[way*LINE_W +: LINE_W] = line;
        if (has2) s[way2*LINE_W +: LINE_W] = line2;
        mem[int'(addr[19:6])] = s;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr, output int acc);
        int n = 0;
        @(negedge clk);
        while (!bus.snp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("snp_ready_timeout", 32'(bus.snp_ready), 32'd1);
        bus.snp_valid = 1'b1;
        bus.snp_op    = op;
        bus.snp_addr  = addr;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.snp_valid = 1'b0;
    endtask

    task automatic wait_wb();
        int n = 0;
        while (!bus.wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wb_valid_seen", 32'(bus.wb_valid), 32'd1);
    endtask

    initial begin
        int acc, prev_acc;
        bus.snp_valid = 1'b0;
        bus.snp_op    = 2'b00;
        bus.snp_addr  = '0;
        bus.wb_ready  = 1'b0;

        //            op     addr          way   line      h2    way2  line2     rsp   wr    e_line    mv    msg   err
        vecs[0]  = '{2'd2, 32'h12300040, 4'd0, 16'h5123, 1'b0, 4'd0, 16'h0000, 2'd0, 1'b1, 16'h0123, 1'b1, 3'd3, 1'b0};
        vecs[1]  = '{2'd0, 32'h55500080, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 2'd2, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{2'd1, 32'h777000C0, 4'd1, 16'h5777, 1'b0, 4'd0, 16'h0000, 2'd2, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{2'd2, 32'h32100100, 4'd2, 16'h9321, 1'b1, 4'd5, 16'h9321, 2'd2, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1};
        vecs[4]  = '{2'd0, 32'h45600140, 4'd7, 16'h9456, 1'b0, 4'd0, 16'h0000, 2'd0, 1'b1, 16'h5456, 1'b0, 3'd0, 1'b0};
        vecs[5]  = '{2'd3, 32'h1110019F, 4'd15, 16'h5111, 1'b0, 4'd0, 16'h0000, 2'd0, 1'b1, 16'h0111, 1'b1, 3'd3, 1'b0};
        vecs[6]  = '{2'd1, 32'h222001C0, 4'd0, 16'h9222, 1'b0, 4'd0, 16'h0000, 2'd2, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1};
        vecs[7]  = '{2'd0, 32'h44400200, 4'd0, 16'h5333, 1'b0, 4'd0, 16'h0000, 2'd2, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vecs[8]  = '{2'd2, 32'h99900240, 4'd4, 16'hF999, 1'b0, 4'd0, 16'h0000, 2'd2, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1};
        vecs[9]  = '{2'd0, 32'hAAA00280, 4'd0, 16'h1AAA, 1'b0, 4'd0, 16'h0000, 2'd2, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vecs[10] = '{2'd0, 32'h654002C0, 4'd3, 16'h5654, 1'b1, 4'd9, 16'h5654, 2'd0, 1'b1, 16'h5654, 1'b0, 3'd0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_snp_ready", 32'(bus.snp_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_addr", bus.wb_addr, 32'd0);
        chk("rst_ta_rd_en", 32'(bus.ta_rd_en), 32'd0);
        chk("rst_ta_wr_en", 32'(bus.ta_wr_en), 32'd0);
        chk("rst_l1_msg_valid", 32'(bus.l1_msg_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;

        // READ hitting M: HITM, S/clean, GETLINE, stalled write-back.
        preload(32'hABC02940, 4'd3, 16'hFABC, 1'b0, 4'd0, 16'h0);
        push_exp(2'd1, 1'b1, 4'd3, 16'h5ABC, 32'hABC02940, 1'b1, 3'd1, 1'b0);
        send(2'd0, 32'hABC02940, acc);
        wait_wb();
        for (int k = 0; k < 3; k++) begin
            chk("wb_stall_valid", 32'(bus.wb_valid), 32'd1);
            chk("wb_stall_addr", bus.wb_addr, 32'hABC02940);
            chk("wb_stall_ready", 32'(bus.snp_ready), 32'd0);
            @(negedge clk);
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
        chk("wb_done_ready", 32'(bus.snp_ready), 32'd1);
        chk("wb_done_valid", 32'(bus.wb_valid), 32'd0);
        chk("wb_done_no_msg", 32'(bus.l1_msg_valid), 32'd0);

        // RWIM hitting M: HITM, GETLINE, write-back, then INVALIDATELINE.
        preload(32'hABC02940, 4'd3, 16'hFABC, 1'b0, 4'd0, 16'h0);
        push_exp(2'd1, 1'b1, 4'd3, 16'h0ABC, 32'hABC02940, 1'b1, 3'd1, 1'b0);
        send(2'd3, 32'hABC02940, acc);
        wait_wb();
        chk("rwim_wb_addr", bus.wb_addr, 32'hABC02940);
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
        chk("inv_msg_valid", 32'(bus.l1_msg_valid), 32'd1);
        chk("inv_msg", 32'(bus.l1_msg), 32'd3);
        chk("inv_addr", bus.l1_addr, 32'hABC02940);
        chk("inv_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("inv_not_ready", 32'(bus.snp_ready), 32'd0);
        @(negedge clk);
        chk("inv_done_ready", 32'(bus.snp_ready), 32'd1);
        chk("inv_done_msg", 32'(bus.l1_msg_valid), 32'd0);

        // Table of single-pass snoops, issued as fast as the responder accepts.
        prev_acc = 0;
        for (int i = 0; i < 11; i++) begin
            preload(vecs[i].addr, vecs[i].way, vecs[i].line, vecs[i].has2, vecs[i].way2, vecs[i].line2);
            push_exp(vecs[i].e_rsp, vecs[i].e_wr, vecs[i].way, vecs[i].e_line, vecs[i].addr,
                     vecs[i].e_msgv, vecs[i].e_msg, vecs[i].e_err);
            send(vecs[i].op, vecs[i].addr, acc);
            if (i > 0) chk($sformatf("v%0d_accept_gap", i), 32'(acc - prev_acc), 32'd3);
            prev_acc = acc;
            @(negedge clk);
            chk($sformatf("v%0d_rd_en", i), 32'(bus.ta_rd_en), 32'd1);
            chk($sformatf("v%0d_rd_index", i), 32'(bus.ta_rd_index), 32'(vecs[i].addr[19:6]));
            @(negedge clk);
            chk($sformatf("v%0d_rsp_latency", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("v%0d_no_wb", i), 32'(bus.wb_valid), 32'd0);
        end

        // Reset while a write-back is pending.
        preload(32'hABC02940, 4'd3, 16'hFABC, 1'b0, 4'd0, 16'h0);
        push_exp(2'd1, 1'b1, 4'd3, 16'h5ABC, 32'hABC02940, 1'b1, 3'd1, 1'b0);
        send(2'd0, 32'hABC02940, acc);
        wait_wb();
        rst_n = 1'b0;
        #1;
        chk("rst_wb_drop_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_drop_ready", 32'(bus.snp_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        preload(32'h55500080, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0);
        push_exp(2'd2, 1'b0, 4'd0, 16'h0000, 32'h55500080, 1'b0, 3'd0, 1'b0);
        send(2'd0, 32'h55500080, acc);
        repeat (5) @(negedge clk);
        chk("post_rst_idle", 32'(bus.snp_ready), 32'd1);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
